// File: rtl/b3_down_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : b3_down_timer_if
//  Description : Control, load-value and status bundle for b3_down_timer.
//  Revision    : 1.0  initial release
// ============================================================================
interface b3_down_timer_if;
  logic       load;
  logic       stop;
  logic       ei;
  logic [1:0] d31_d30;
  logic [1:0] d21_d20;
  logic [1:0] d11_d10;
  logic [1:0] d01_d00;
  logic [1:0] q31_q30;
  logic [1:0] q21_q20;
  logic [1:0] q11_q10;
  logic [1:0] q01_q00;
  logic       busy;
  logic       done;
  logic       zero;

  modport master (
    output load, stop, ei, d31_d30, d21_d20, d11_d10, d01_d00,
    input  q31_q30, q21_q20, q11_q10, q01_q00, busy, done, zero
  );

  modport slave (
    input  load, stop, ei, d31_d30, d21_d20, d11_d10, d01_d00,
    output q31_q30, q21_q20, q11_q10, q01_q00, busy, done, zero
  );
endinterface
`default_nettype wire

// File: rtl/b3_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : b3_down_timer
//  Description : 4-digit base-3 loadable down counter with one-cycle done
//                pulse. Optional macro B3_DOWN_TIMER_AUTORELOAD_EN makes the
//                terminal tick reload the last loaded value (periodic mode).
//  Revision    : 1.0  initial release
// ============================================================================
module b3_down_timer (
  input  wire logic       clock,
  input  wire logic       reset_,
  b3_down_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state, w_next_state;
  logic [7:0] r_q, w_next_q;
  logic [7:0] w_load_val;
  logic [7:0] w_dec_q;
  logic       w_borrow;

`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
  logic [7:0] r_reload, w_next_reload;
  logic       r_ar_done, w_next_ar_done;
`endif

  // Digit code 11 is illegal; clamp it to the largest legal digit
  function automatic logic [1:0] clamp_digit(input logic [1:0] d);
    return (d == 2'b11) ? 2'b10 : d;
  endfunction

  assign w_load_val = {clamp_digit(bus.d31_d30), clamp_digit(bus.d21_d20),
                       clamp_digit(bus.d11_d10), clamp_digit(bus.d01_d00)};

  // Base-3 decrement: a 00 digit wraps to 10 and passes the borrow upward
  always_comb begin
    w_dec_q  = r_q;
    w_borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_borrow) begin
        if (r_q[2*i +: 2] == 2'b00) begin
          w_dec_q[2*i +: 2] = 2'b10;
        end else begin
          w_dec_q[2*i +: 2] = r_q[2*i +: 2] - 2'b01;
          w_borrow          = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_q     = r_q;
`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
    w_next_reload  = r_reload;
    w_next_ar_done = 1'b0;
`endif
    if (bus.load) begin
      w_next_q     = w_load_val;
      w_next_state = (w_load_val != 8'd0) ? ST_RUN : ST_DONE;
`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
      w_next_reload = w_load_val;
`endif
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.stop) begin
            w_next_state = ST_IDLE;
          end else if (bus.ei) begin
            if (w_dec_q == 8'd0) begin
`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
              w_next_q       = r_reload;
              w_next_ar_done = 1'b1;
`else
              w_next_q     = w_dec_q;
              w_next_state = ST_DONE;
`endif
            end else begin
              w_next_q = w_dec_q;
            end
          end
        end
        ST_DONE: w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
      r_q     <= 8'd0;
`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
      r_reload  <= 8'd0;
      r_ar_done <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_q     <= w_next_q;
`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
      r_reload  <= w_next_reload;
      r_ar_done <= w_next_ar_done;
`endif
    end
  end

  assign bus.q31_q30 = r_q[7:6];
  assign bus.q21_q20 = r_q[5:4];
  assign bus.q11_q10 = r_q[3:2];
  assign bus.q01_q00 = r_q[1:0];
  assign bus.busy    = (r_state == ST_RUN);
  assign bus.zero    = (r_q == 8'd0);
`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
  assign bus.done    = (r_state == ST_DONE) | r_ar_done;
`else
  assign bus.done    = (r_state == ST_DONE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_b3_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_b3_down_timer
//  Description : Directed vector bench for b3_down_timer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_b3_down_timer;

  logic clock;
  logic reset_;
  int   n_tests;
  int   n_fail;

  b3_down_timer_if bus ();

  b3_down_timer dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       load;
    logic       stop;
    logic       ei;
    logic [7:0] d;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic st, input logic e, input logic [7:0] d,
                     input logic [7:0] q, input logic b, input logic dn);
    vec_t v;
    v.load = ld; v.stop = st; v.ei = e; v.d = d;
    v.q = q; v.busy = b; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic st, input logic e, input logic [7:0] d);
    bus.load    = ld;
    bus.stop    = st;
    bus.ei      = e;
    bus.d31_d30 = d[7:6];
    bus.d21_d20 = d[5:4];
    bus.d11_d10 = d[3:2];
    bus.d01_d00 = d[1:0];
  endtask

  task automatic check(input string name, input logic [7:0] eq, input logic eb, input logic ed);
    logic [7:0] aq;
    logic       ez;
    aq = {bus.q31_q30, bus.q21_q20, bus.q11_q10, bus.q01_q00};
    ez = (eq == 8'd0);
    n_tests++;
    if (aq !== eq || bus.busy !== eb || bus.done !== ed || bus.zero !== ez) begin
      n_fail++;
      $display("FAIL %s: got q=%b busy=%b done=%b zero=%b, want q=%b busy=%b done=%b zero=%b",
               name, aq, bus.busy, bus.done, bus.zero, eq, eb, ed, ez);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are checked 1ns after the next one.
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Basic countdown 0002
    add(1, 0, 0, 8'h02, 8'h02, 1, 0);
    add(0, 0, 1, 8'h00, 8'h01, 1, 0);
`ifdef B3_DOWN_TIMER_AUTORELOAD_EN
    add(0, 0, 1, 8'h00, 8'h02, 1, 1);
    add(0, 0, 1, 8'h00, 8'h01, 1, 0);
    add(0, 0, 0, 8'h00, 8'h01, 1, 0);
    add(0, 0, 1, 8'h00, 8'h02, 1, 1);
    add(0, 0, 1, 8'h00, 8'h01, 1, 0);
    add(0, 1, 1, 8'h00, 8'h01, 0, 0);
`else
    add(0, 0, 1, 8'h00, 8'h00, 0, 1);
    add(0, 0, 1, 8'h00, 8'h00, 0, 0);
    // Load during DONE, then terminal again
    add(1, 0, 0, 8'h01, 8'h01, 1, 0);
    add(0, 0, 1, 8'h00, 8'h00, 0, 1);
    add(1, 0, 1, 8'h02, 8'h02, 1, 0);
    add(0, 1, 0, 8'h00, 8'h02, 0, 0);
`endif
    // Borrow ripple 1000 -> 0222, then ei in IDLE is ignored
    add(1, 0, 0, 8'h40, 8'h40, 1, 0);
    add(0, 0, 1, 8'h00, 8'h2A, 1, 0);
    add(0, 1, 0, 8'h00, 8'h2A, 0, 0);
    add(0, 0, 1, 8'h00, 8'h2A, 0, 0);
    // Single-digit borrow 0010 -> 0002
    add(1, 0, 0, 8'h04, 8'h04, 1, 0);
    add(0, 0, 1, 8'h00, 8'h02, 1, 0);
    // Load beats ei; clamp of illegal digit
    add(1, 0, 1, 8'h99, 8'h99, 1, 0);
    add(0, 1, 0, 8'h00, 8'h99, 0, 0);
    add(1, 0, 0, 8'h03, 8'h02, 1, 0);
    add(1, 1, 1, 8'hFF, 8'hAA, 1, 0);
    // Stop after two ticks from 0200
    add(1, 0, 0, 8'h20, 8'h20, 1, 0);
    add(0, 0, 1, 8'h00, 8'h1A, 1, 0);
    add(0, 0, 1, 8'h00, 8'h19, 1, 0);
    add(0, 1, 1, 8'h00, 8'h19, 0, 0);
    add(0, 0, 1, 8'h00, 8'h19, 0, 0);
    add(0, 1, 0, 8'h00, 8'h19, 0, 0);
    // Load of 0000 -> DONE then IDLE, ei during DONE ignored
    add(1, 0, 0, 8'h00, 8'h00, 0, 1);
    add(0, 0, 1, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0);

    step;
    step;
    check("reset_init", 8'h00, 1'b0, 1'b0);
    reset_ = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].stop, vecs[i].ei, vecs[i].d);
      step;
      check($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].done);
    end

    // Reset mid-RUN at 1021
    drive(1'b1, 1'b0, 1'b0, 8'h49);
    step;
    check("load_1021", 8'h49, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    reset_ = 1'b0;
    step;
    check("reset_mid_run", 8'h00, 1'b0, 1'b0);
    // Reset outranks load
    drive(1'b1, 1'b0, 1'b0, 8'h12);
    step;
    check("reset_over_load", 8'h00, 1'b0, 1'b0);
    reset_ = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    step;
    check("idle_after_reset", 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/b3_down_timer.md
Name: b3_down_timer

Overview:
- 4-digit base-3 loadable down counter/timer; the decrementing counterpart of the team's 4-digit base-3 up counter.
- Digits use the same 2-bit-per-digit encoding: 00=0, 01=1, 10=2; 11 is illegal.
- Loaded with a start value, decrements once per enabled tick, and pulses done when it reaches 0000.
- Used as a programmable interval/timeout generator next to the up counters.

Parameters:
- None. Digit count (4) and base (3) are fixed.

Ports:
- clock  in  1  system clock, rising edge
- reset_  in  1  synchronous active-low reset
- load  in  1  load request; sample d* and start counting
- stop  in  1  abort a running count
- ei  in  1  decrement enable (tick)
- d31_d30, d21_d20, d11_d10, d01_d00  in  2 each  load value, digit 3 (MS) to digit 0 (LS)
- q31_q30, q21_q20, q11_q10, q01_q00  out  2 each  current value
- busy  out  1  high while in RUN
- done  out  1  one-cycle terminal pulse
- zero  out  1  combinational: current value == 0000

Behaviour:
- Interface: one clock, clock; reset_ is synchronous and active-low.
- All state is registered on the rising edge of clock.
- Reset (reset_=0 at an edge): q=0000, state IDLE, busy=0, done=0, zero=1. Reset has priority over every other input, including mid-RUN.
- State machine, registered:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1. Lasts exactly one cycle.
- Priority at each edge: reset_ > load > stop > ei.
- load=1 in any state:
  - q takes the d* value after the edge. Any digit equal to 11 is clamped to 10.
  - The loaded value is also stored in an internal reload register.
  - Next state is RUN if the loaded value is nonzero, DONE if it is 0000.
  - ei and stop are ignored in that cycle.
- stop=1 (no load) in RUN: next state IDLE, q held, no done pulse. stop in IDLE or DONE has no effect.
- ei=1 in RUN (no load, no stop): q decrements by 1 in base 3.
  - Digit 0 decrements; a digit at 00 wraps to 10 and borrows into the next digit.
  - Borrow ripples through all 4 digits.
- Terminal: when the decrement result is 0000 (q was 0001), next state is DONE. done=1 and busy=0 in the same cycle that q shows 0000.
- DONE always moves to IDLE on the next edge unless load=1, in which case it moves to RUN/DONE per the load rule.
- ei in IDLE or DONE: ignored; q held.
- RUN with q=0000 is unreachable.
- Latency: one edge from load or ei to the updated q. Outputs busy and done are decoded directly from the state register, with no extra delay.

Optional Feature:
- Macro: B3_DOWN_TIMER_AUTORELOAD_EN
- Defined:
  - On the terminal decrement, q takes the reload register value instead of 0000.
  - done pulses for one cycle; state stays RUN; busy stays 1.
  - Periodic operation: period = reload value in ticks.
  - stop or reset_ is the only exit.
  - A load of 0000 still goes to DONE and then IDLE.
- Not defined: terminal behaviour exactly as in Behaviour; the reload register may be omitted.

Test Plan:
- Reset: reset_=0 for one edge during RUN at q=1021 -> q=0000, busy=0, done=0, zero=1.
- Basic countdown: load 0002, then ei=1 continuously -> q=0002, 0001, 0000 on successive cycles. busy=1, 1, 0; done=1 only on the 0000 cycle, then done=0 and IDLE.
- Borrow ripple: load 1000, single ei pulse -> q=0222. Further ei in IDLE after the terminal sequence leaves q unchanged.
- Priority and clamp: load with d=2121 and ei=1 in the same cycle -> q=2121 (ei ignored). Load d01_d00=11 with other digits 00 -> q=0002.
- Stop: load 0200, two ei ticks -> q=0121, then stop=1 -> IDLE, busy=0, q=0121 held, done never asserted. Loading 0000 -> done=1 the next cycle, then IDLE.
- Autoreload (macro defined): load 0002, ei constant -> q=0002, 0001, 0002 (done=1), 0001, 0002 (done=1)…; busy stays 1. stop -> IDLE.
